instr_fetch: RTL and testbench

Instruction-supply block for the 4-bit CPU: a host loads a 16-word program into it over a valid/ready handshake, then it feeds the program counter. It holds `set_pc` asserted while idle or loading, so the PC is parked at address 0. In run mode it drives `ins` from its memory at the address given by `pc_curr`. It sits on the far side of the PC's `INS`/`PC_CURR`/`set_pc` interface: it consumes the PC's address and produces the PC's control and instruction inputs.

---
 rtl/instr_fetch.sv | 124 ++++++++++++
 tb/tb_instr_fetch.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction supply for the 4-bit CPU: loads a program over valid/ready,
// then serves mem[pc_curr] to the PC while holding set_pc low in RUN.
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   ld_start              - host request to (re)load a program
//   ld_valid/ld_data      - host word handshake, ld_last marks final word
//   ld_ready              - block accepts a word this cycle
//   ld_err                - sticky: load overflowed without ld_last
//   pc_curr               - current PC address
//   ins                   - instruction to the PC / decode
//   set_pc                - parks the PC at 0 while high
//   running               - program is executing
module instr_fetch #(
  parameter int              AW      = 4,
  parameter int              DW      = 16,
  parameter logic [DW-1:0]   NOP_INS = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          ld_err,
  input  logic [AW-1:0] pc_curr,
  output logic [DW-1:0] ins,
  output logic          set_pc,
  output logic          running
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PRIME,
    S_RUN
  } state_t;

  localparam int            DEPTH     = 1 << AW;
  localparam logic [AW-1:0] LAST_ADDR = '1;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW:0]   prog_len_q, prog_len_d;
  logic          ld_err_q, ld_err_d;
  logic          set_pc_q, running_q, ld_ready_q;
  logic          xfer;

  logic [DW-1:0] mem [DEPTH];

  // ld_ready_q is only set in LOAD, so this also qualifies the state.
  assign xfer = ld_valid & ld_ready_q;

  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    prog_len_d = prog_len_q;
    ld_err_d   = ld_err_q;
    unique case (state_q)
      S_IDLE, S_RUN: begin
        if (ld_start) begin
          state_d    = S_LOAD;
          wr_addr_d  = '0;
          prog_len_d = '0;
          ld_err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          wr_addr_d  = wr_addr_q + 1'b1;
          prog_len_d = prog_len_q + 1'b1;
          if (ld_last) begin
            state_d = S_PRIME;
          end else if (wr_addr_q == LAST_ADDR) begin
            state_d  = S_IDLE;
            ld_err_d = 1'b1;
          end
        end
      end
      S_PRIME: state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered off the next state so they carry no
  // combinational path from the host or PC inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_addr_q  <= '0;
      prog_len_q <= '0;
      ld_err_q   <= 1'b0;
      set_pc_q   <= 1'b1;
      running_q  <= 1'b0;
      ld_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      prog_len_q <= prog_len_d;
      ld_err_q   <= ld_err_d;
      set_pc_q   <= (state_d != S_RUN);
      running_q  <= (state_d == S_RUN);
      ld_ready_q <= (state_d == S_LOAD);
    end
  end

  // Program memory is not reset; prog_len gates what is reachable.
  always_ff @(posedge clk) begin
    if (!rst && xfer) begin
      mem[wr_addr_q] <= ld_data;
    end
  end

  // Asynchronous read: the PC samples ins on the same edge it branches.
  assign ins = (running_q && ({1'b0, pc_curr} < prog_len_q))
             ? mem[pc_curr] : NOP_INS;

  assign ld_ready = ld_ready_q;
  assign ld_err   = ld_err_q;
  assign set_pc   = set_pc_q;
  assign running  = running_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: loaded words are queued as expected
// instructions and popped when the program is read back in RUN.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_start;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_err;
  logic [3:0]  pc_curr;
  logic [15:0] ins;
  logic        set_pc;
  logic        running;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] sb_q [$];

  instr_fetch #(.AW(4), .DW(16), .NOP_INS(16'h0000)) dut (
    .clk      (clk),
    .rst      (rst),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .ld_err   (ld_err),
    .pc_curr  (pc_curr),
    .ins      (ins),
    .set_pc   (set_pc),
    .running  (running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input string tag, input logic rdy, input logic spc,
                     input logic run, input logic err);
    check({tag, ".ld_ready"}, {31'd0, ld_ready}, {31'd0, rdy});
    check({tag, ".set_pc"},   {31'd0, set_pc},   {31'd0, spc});
    check({tag, ".running"},  {31'd0, running},  {31'd0, run});
    check({tag, ".ld_err"},   {31'd0, ld_err},   {31'd0, err});
  endtask

  task automatic start();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic send(input logic [15:0] w, input logic last);
    ld_valid = 1'b1;
    ld_data  = w;
    ld_last  = last;
    sb_q.push_back(w);
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic read_pc(input string tag, input logic [3:0] pc);
    logic [15:0] e;
    pc_curr = pc;
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check(tag, {16'd0, ins}, {16'd0, e});
    end
  endtask

  task automatic read_nop(input string tag, input logic [3:0] pc);
    pc_curr = pc;
    #1;
    check(tag, {16'd0, ins}, 32'h0);
  endtask

  initial begin
    logic [15:0] bp_w [3];
    logic        bp_v [5];
    int          k;
    rst      = 1'b1;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    pc_curr  = '0;
    tick();
    tick();
    rst = 1'b0;
    ctl("rst", 1'b0, 1'b1, 1'b0, 1'b0);
    check("rst.ins", {16'd0, ins}, 32'h0);
    tick();
    tick();
    ctl("idle", 1'b0, 1'b1, 1'b0, 1'b0);

    // load and run
    start();
    ctl("ld1.start", 1'b1, 1'b1, 1'b0, 1'b0);
    send(16'h0300, 1'b0);
    send(16'h0470, 1'b0);
    send(16'h04E0, 1'b1);
    ctl("ld1.prime", 1'b0, 1'b1, 1'b0, 1'b0);
    check("ld1.prime.ins", {16'd0, ins}, 32'h0);
    tick();
    ctl("ld1.run", 1'b0, 1'b0, 1'b1, 1'b0);
    read_pc("ld1.pc0", 4'd0);
    read_pc("ld1.pc1", 4'd1);
    read_pc("ld1.pc2", 4'd2);
    read_nop("ld1.pc5", 4'd5);

    // reload during RUN, with backpressure
    pc_curr = 4'd0;
    start();
    ctl("reload", 1'b1, 1'b1, 1'b0, 1'b0);
    check("reload.ins", {16'd0, ins}, 32'h0);
    bp_w = '{16'hA1B2, 16'hC3D4, 16'hE5F6};
    bp_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    k = 0;
    for (int i = 0; i < 5; i++) begin
      if (bp_v[i]) begin
        send(bp_w[k], k == 2);
        k++;
      end else begin
        ld_valid = 1'b0;
        ld_data  = 16'hDEAD;
        ld_last  = 1'b1;
        tick();
        ld_last  = 1'b0;
      end
    end
    ctl("bp.prime", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    ctl("bp.run", 1'b0, 1'b0, 1'b1, 1'b0);
    read_pc("bp.pc0", 4'd0);
    read_pc("bp.pc1", 4'd1);
    read_pc("bp.pc2", 4'd2);
    read_nop("bp.pc3", 4'd3);

    // overflow: 16 words, no ld_last
    start();
    for (int i = 0; i < 16; i++) begin
      send(16'h1000 + 16'(i), 1'b0);
    end
    sb_q.delete();
    ctl("ovf", 1'b0, 1'b1, 1'b0, 1'b1);
    read_nop("ovf.ins", 4'd0);
    tick();
    ctl("ovf.hold", 1'b0, 1'b1, 1'b0, 1'b1);

    // ld_start with ld_valid together: word not taken
    ld_valid = 1'b1;
    ld_data  = 16'hBEEF;
    ld_last  = 1'b1;
    start();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ctl("ovf.clr", 1'b1, 1'b1, 1'b0, 1'b0);

    // full 16-word program with ld_last on word 16
    for (int i = 0; i < 16; i++) begin
      send(16'h2000 + 16'(i * 7), i == 15);
    end
    ctl("full.prime", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    ctl("full.run", 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      read_pc($sformatf("full.pc%0d", i), 4'(i));
    end

    // reset mid-load
    start();
    send(16'h5555, 1'b0);
    send(16'h6666, 1'b0);
    sb_q.delete();
    rst = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 16'h7777;
    tick();
    rst = 1'b0;
    ld_valid = 1'b0;
    ctl("rstmid", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    ctl("rstmid.idle", 1'b0, 1'b1, 1'b0, 1'b0);
    start();
    send(16'h0300, 1'b1);
    tick();
    ctl("one.run", 1'b0, 1'b0, 1'b1, 1'b0);
    read_pc("one.pc0", 4'd0);
    read_nop("one.pc1", 4'd1);
    check("sb.left", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
